// File: rtl/prince_ti_round_ctrl.sv
// Round sequencer for the 3-share threshold PRINCE datapath: walks load, five forward
// rounds, the two-pass middle layer, five inverse rounds and final whitening.
module prince_ti_round_ctrl #(
  parameter int STAGES = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnd_valid,
  output logic       busy,
  output logic       load_en,
  output logic       state_en,
  output logic [1:0] stage_idx,
  output logic [3:0] round_idx,
  output logic       inv_sel,
  output logic       mlayer_en,
  output logic       mid_sel,
  output logic       rnd_req,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FWD, S_MID, S_INV, S_FINAL, S_DONE
  } state_t;

  localparam logic [1:0] LAST_STAGE = 2'(STAGES - 1);

  state_t     state_q, state_d;
  logic [1:0] stage_q, stage_d;
  logic [3:0] round_q, round_d;
  logic       pass_q, pass_d;

  logic in_sbox;
  logic last_stage;
  logic stall;

  // Every S-box pass draws fresh masks on its first stage; without them nothing moves.
  assign in_sbox    = (state_q == S_FWD) || (state_q == S_MID) || (state_q == S_INV);
  assign last_stage = (stage_q == LAST_STAGE);
  assign stall      = in_sbox && (stage_q == 2'd0) && !rnd_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stage_q <= 2'd0;
      round_q <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      round_q <= round_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    round_d = round_q;
    pass_d  = pass_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          stage_d = 2'd0;
          round_d = 4'd0;
          pass_d  = 1'b0;
        end
      end
      S_LOAD: begin
        state_d = S_FWD;
        stage_d = 2'd0;
        round_d = 4'd1;
      end
      S_FWD: begin
        if (!stall) begin
          if (last_stage) begin
            stage_d = 2'd0;
            if (round_q == 4'd5) begin
              state_d = S_MID;
              pass_d  = 1'b0;
            end else begin
              round_d = round_q + 4'd1;
            end
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end
      S_MID: begin
        if (!stall) begin
          if (last_stage) begin
            stage_d = 2'd0;
            if (pass_q) begin
              state_d = S_INV;
              round_d = 4'd6;
              pass_d  = 1'b0;
            end else begin
              pass_d = 1'b1;
            end
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end
      S_INV: begin
        if (!stall) begin
          if (last_stage) begin
            stage_d = 2'd0;
            if (round_q == 4'd10) begin
              state_d = S_FINAL;
              round_d = 4'd11;
            end else begin
              round_d = round_q + 4'd1;
            end
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end
      end
      S_FINAL: begin
        state_d = S_DONE;
        round_d = 4'd0;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    load_en   = 1'b0;
    state_en  = 1'b0;
    stage_idx = 2'd0;
    round_idx = 4'd0;
    inv_sel   = 1'b0;
    mlayer_en = 1'b0;
    mid_sel   = 1'b0;
    rnd_req   = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_LOAD: begin
        busy     = 1'b1;
        load_en  = 1'b1;
        state_en = 1'b1;
      end
      S_FWD: begin
        busy      = 1'b1;
        state_en  = !stall;
        stage_idx = stage_q;
        round_idx = round_q;
        mlayer_en = last_stage;
        rnd_req   = (stage_q == 2'd0);
      end
      S_MID: begin
        busy      = 1'b1;
        state_en  = !stall;
        stage_idx = stage_q;
        round_idx = round_q;
        inv_sel   = pass_q;
        mlayer_en = last_stage && !pass_q;
        mid_sel   = last_stage && !pass_q;
        rnd_req   = (stage_q == 2'd0);
      end
      S_INV: begin
        // M^-1 precedes the inverse S-box, so the linear layer sits on stage 0.
        busy      = 1'b1;
        state_en  = !stall;
        stage_idx = stage_q;
        round_idx = round_q;
        inv_sel   = 1'b1;
        mlayer_en = (stage_q == 2'd0);
        rnd_req   = (stage_q == 2'd0);
      end
      S_FINAL: begin
        busy      = 1'b1;
        state_en  = 1'b1;
        round_idx = 4'd11;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_prince_ti_round_ctrl.sv
// Scoreboard bench for prince_ti_round_ctrl: stimulus queues per-operation expectations,
// a negedge monitor accumulates the observed sequence and checks it on each done pulse.
module tb_prince_ti_round_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rnd_valid = 1'b1;
  logic       busy, load_en, state_en, inv_sel, mlayer_en, mid_sel, rnd_req, done;
  logic [1:0] stage_idx;
  logic [3:0] round_idx;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int done_cyc;
    int load_cyc;
    int n_busy;
    int round_sum;
    int n_ml;
    int n_mid;
    int n_inv;
    int n_req;
    int n_en;
  } exp_t;

  exp_t sb[$];

  int a_load, a_busy, a_rsum, a_ml, a_mid, a_inv, a_req, a_en;

  prince_ti_round_ctrl #(.STAGES(3)) dut (
    .clk(clk), .rst(rst), .start(start), .rnd_valid(rnd_valid),
    .busy(busy), .load_en(load_en), .state_en(state_en), .stage_idx(stage_idx),
    .round_idx(round_idx), .inv_sel(inv_sel), .mlayer_en(mlayer_en),
    .mid_sel(mid_sel), .rnd_req(rnd_req), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int all_outs();
    return int'({busy, load_en, state_en, stage_idx, round_idx,
                 inv_sel, mlayer_en, mid_sel, rnd_req, done});
  endfunction

  // Monitor: samples 2 time units after the falling edge, after stimulus has settled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!rst) begin
      if (load_en) begin
        a_load = cyc; a_busy = 0; a_rsum = 0; a_ml = 0;
        a_mid = 0; a_inv = 0; a_req = 0; a_en = 0;
      end
      if (busy) begin
        a_busy++;
        a_rsum += int'(round_idx);
        if (mlayer_en) a_ml++;
        if (mid_sel)   a_mid++;
        if (inv_sel)   a_inv++;
        if (rnd_req)   a_req++;
        if (state_en)  a_en++;
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("load_cycle", a_load, e.load_cyc);
          chk("busy_cycles", a_busy, e.n_busy);
          chk("round_sum", a_rsum, e.round_sum);
          chk("mlayer_count", a_ml, e.n_ml);
          chk("mid_count", a_mid, e.n_mid);
          chk("inv_count", a_inv, e.n_inv);
          chk("rnd_req_count", a_req, e.n_req);
          chk("state_en_count", a_en, e.n_en);
          chk("busy_in_done", int'(busy), 0);
          $display("op done at cycle %0d latency=%0d busy=%0d mlayer=%0d",
                   cyc, cyc - a_load + 1, a_busy, a_ml);
        end
      end
    end
  end

  // Start one operation; stalls are the number of starved cycles placed in FWD round 3.
  // Unstalled round_idx sum: 0 + 3*(1+..+5) + 6*5 + 3*(6+..+10) + 11 = 206.
  task automatic start_op(input int stalls, output int s);
    exp_t e;
    s = cyc;
    start = 1'b1;
    e.done_cyc  = s + 39 + stalls;
    e.load_cyc  = s + 1;
    e.n_busy    = 38 + stalls;
    e.round_sum = 206 + 3 * stalls;
    e.n_ml      = 11;
    e.n_mid     = 1;
    e.n_inv     = 18;
    e.n_req     = 12 + stalls;
    e.n_en      = 38;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 120) begin
      @(negedge clk);
      k++;
    end
    chk("done_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int s;
    int k;
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int k;
    // Reset then idle.
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("idle_outputs", all_outs(), 0);
    end

    // Nominal run.
    start_op(0, s);
    wait_done();

    // Starvation: four cycles without randomness at the first stage 0 of round 3.
    start_op(4, s);
    k = 0;
    #1;
    while (!(busy && round_idx == 4'd3 && stage_idx == 2'd0) && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("round3_reached", int'(round_idx), 3);
    for (int i = 0; i < 4; i++) begin
      rnd_valid = 1'b0;
      #1;
      chk("stall_state_en", int'(state_en), 0);
      chk("stall_round", int'(round_idx), 3);
      chk("stall_stage", int'(stage_idx), 0);
      chk("stall_rnd_req", int'(rnd_req), 1);
      @(negedge clk);
      #1;
    end
    rnd_valid = 1'b1;
    wait_done();

    // Missing randomness when none is requested must not stall.
    start_op(0, s);
    k = 0;
    #1;
    while (!(busy && stage_idx == 2'd1) && k < 20) begin
      @(negedge clk);
      #1;
      k++;
    end
    rnd_valid = 1'b0;
    #1;
    chk("no_stall_state_en", int'(state_en), 1);
    chk("no_stall_rnd_req", int'(rnd_req), 0);
    @(negedge clk);
    #1;
    rnd_valid = 1'b1;
    wait_done();

    // start re-asserted at cycle 20 and during DONE: ignored.
    start_op(0, s);
    repeat (19) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    #1;
    while (!done && k < 60) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_seen", int'(done), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("idle_after_done", int'(busy), 0);
    repeat (10) @(negedge clk);
    chk("sb_empty_after_ignore", sb.size(), 0);

    // Reset mid-INV abandons the operation.
    start_op(0, s);
    repeat (24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("abort_outputs", all_outs(), 0);
    sb.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    chk("abort_idle", all_outs(), 0);
    start_op(0, s);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prince_ti_round_ctrl.md
# prince_ti_round_ctrl

Sequencer for the 3-share threshold-implemented PRINCE core. It steps the shared state registers through load, five forward rounds, the middle layer, five inverse rounds and the final key whitening. It drives the stage/affine selection of the decomposed S-box datapath, including the per-share affine output layers, and stalls the datapath whenever fresh mask randomness is not available. One instance sits beside the share datapath; it carries no data.

## Interface
- STAGES, 3: register stages per S-box evaluation (quadratic stage, quadratic stage, affine/linear stage); legal 2..4.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request to encrypt; sampled only in IDLE.
- rnd_valid  in  1  fresh randomness present on the mask bus this cycle.
- busy  out  1  operation in progress.
- load_en  out  1  load plaintext shares and whitening key into state registers.
- state_en  out  1  clock enable of the share state registers.
- stage_idx  out  2  current S-box stage, 0..STAGES-1.
- round_idx  out  4  round-constant index, 0..11.
- inv_sel  out  1  select inverse S-box decomposition and inverse affine layers.
- mlayer_en  out  1  apply M (forward) or M^-1 (inverse) linear layer this cycle.
- mid_sel  out  1  apply middle M' layer in place of M/M^-1.
- rnd_req  out  1  datapath consumes randomness this cycle.
- done  out  1  one-cycle pulse: ciphertext shares valid in state registers.

## Operation
- States: IDLE, LOAD, FWD, MID, INV, FINAL, DONE.
- IDLE: start=1 moves to LOAD; all outputs 0.
- LOAD: one cycle. load_en=1, state_en=1, round_idx=0. Always moves to FWD.
- FWD: rounds 1..5. round_idx = round, stage_idx counts 0..STAGES-1, inv_sel=0. mlayer_en=1 on the last stage. After round 5 ends, moves to MID.
- MID: two S-box passes with round_idx=5.
  - Pass 1 uses inv_sel=0.
  - Pass 2 uses inv_sel=1.
  - mid_sel=1 and mlayer_en=1 on the last stage of pass 1 only.
- INV: rounds 6..10. round_idx = round, inv_sel=1. mlayer_en=1 on the first stage, so M^-1 is applied before the inverse S-box. After round 10 ends, moves to FINAL.
- FINAL: one cycle. round_idx=11, state_en=1 for the final key/RC11 add. Moves to DONE.
- DONE: done=1 for one cycle; busy=0 in this cycle. Returns to IDLE.
- busy=1 in LOAD, FWD, MID, INV and FINAL.
- Randomness:
  - rnd_req=1 in every stage_idx=0 cycle of FWD, MID and INV.
  - If rnd_req=1 and rnd_valid=0, the controller stalls: state_en=0, and all counters, state and outputs hold.
  - In every other busy cycle state_en=1.
  - rnd_valid is ignored when rnd_req=0.
- start while busy or in DONE is ignored. It is not queued.
- rst=1 in any cycle forces IDLE and all outputs to 0 on the next edge. An operation in flight is abandoned with no done pulse.
- Counters:
  - stage counter is 2 bits and wraps STAGES-1 -> 0, incrementing the round counter.
  - round counter is 4 bits and never exceeds 11.

## Timing
- Reset values: busy, load_en, state_en, stage_idx, round_idx, inv_sel, mlayer_en, mid_sel, rnd_req and done are all 0.
- All outputs are registered state decodes and are valid in the cycle of the corresponding state.
- start sampled at edge t gives LOAD in cycle t+1.
- Unstalled latency: LOAD 1 + FWD 5·STAGES + MID 2·STAGES + INV 5·STAGES + FINAL 1 = 12·STAGES+2 cycles. done then pulses in the next cycle.
- With STAGES=3: start at edge 0, LOAD in cycle 1, FINAL in cycle 38, done in cycle 39.
- Each stall cycle adds exactly one cycle of latency.
- Back-to-back operation: start held high in the DONE cycle is ignored. Re-asserting start in the first IDLE cycle begins a new operation, so the minimum start-to-start spacing is 12·STAGES+4 cycles.

## Test plan
- Reset then idle: rst for 2 cycles, start=0 -> every output 0 for 10 cycles.
- Nominal run, STAGES=3, rnd_valid=1: start pulse -> load_en in cycle 1 and done in cycle 39. Round_idx sequence is 0, then 1..5 (3 cycles each), 5 for 6 cycles, 6..10, then 11. mlayer_en appears 11 times and mid_sel once.
- Randomness starvation: rnd_valid=0 for 4 cycles at the first stage_idx=0 of round 3 -> state_en=0 and outputs frozen for 4 cycles; done arrives in cycle 43.
- rnd_valid=0 on a non-rnd_req cycle -> no stall; done still in cycle 39.
- start re-asserted in cycle 20 and in the DONE cycle -> ignored; exactly one done pulse.
- rst asserted in cycle 25, mid-INV -> next cycle all outputs 0 and no done. A fresh start afterwards completes in 39 cycles.
